// File: rtl/fetch_pkt_dram.sv
// ---------------------------------------------------------------------------
// fetch_pkt_dram
// Read side of the DRAM output-queue ring. Whenever the writer has filled at
// least one ring slot and the downstream egress FIFO can absorb a whole block,
// a block read is requested from the DRAM controller. The returned words are
// streamed straight into the FIFO, and the reader slot index advances within
// the programmable ring bounds.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_oq_wr_addr            writer slot index (next slot the writer fills)
//   o_oq_rd_addr            reader slot index (next slot to fetch)
//   o_dram_rd_req/ptr       block read request and DRAM word address of block
//   i_dram_rd_ack           request accepted by the controller
//   i_dram_rd_data/_vld     returned DRAM word and its valid strobe
//   i_dram_rd_done          last word of the block (may coincide with vld)
//   o_fifo_din/o_fifo_wr_en downstream FIFO write port
//   i_fifo_wr_data_count    downstream FIFO occupancy
//   i_fifo_full             downstream FIFO full
//   i_block_addr_hi/lo      ring bounds (registered, one cycle latency)
//   i_ctrl                  bit OQ_CONTROL_INITIALIZE_OQ_POS reinitialises ring
//   o_dram_rd_words         pulse per word written to the FIFO
//   o_blocks_fetched        pulse per completed block
//   o_overflow_err          sticky: a word arrived while the FIFO was full
// ---------------------------------------------------------------------------
module fetch_pkt_dram #(
  parameter int DATA_WIDTH                    = 64,
  parameter int CTRL_WIDTH                    = DATA_WIDTH / 8,
  parameter int DRAM_ADDR_WIDTH               = 22,
  parameter int DRAM_DATA_WIDTH               = 2 * (DATA_WIDTH + CTRL_WIDTH),
  parameter int DRAM_BLOCK_RDWR_ADDR_WIDTH    = 3,
  parameter int DRAM_BLOCK_SIZE               = 128,
  parameter int FIFO_DEPTH                    = 512,
  parameter int DEFAULT_ADDR                  = 0,
  parameter int CTRL_BITS                     = 2,
  parameter int OQ_CONTROL_INITIALIZE_OQ_POS  = 0,
  parameter int FIFO_CNT_WIDTH                = $clog2(FIFO_DEPTH)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] i_oq_wr_addr,
  output logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] o_oq_rd_addr,
  output logic                                  o_dram_rd_req,
  output logic [DRAM_ADDR_WIDTH-1:0]            o_dram_rd_ptr,
  input  logic                                  i_dram_rd_ack,
  input  logic [DRAM_DATA_WIDTH-1:0]            i_dram_rd_data,
  input  logic                                  i_dram_rd_data_vld,
  input  logic                                  i_dram_rd_done,
  output logic [DRAM_DATA_WIDTH-1:0]            o_fifo_din,
  output logic                                  o_fifo_wr_en,
  input  logic [FIFO_CNT_WIDTH-1:0]             i_fifo_wr_data_count,
  input  logic                                  i_fifo_full,
  input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] i_block_addr_hi,
  input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] i_block_addr_lo,
  input  logic [CTRL_BITS-1:0]                  i_ctrl,
  output logic                                  o_dram_rd_words,
  output logic                                  o_blocks_fetched,
  output logic                                  o_overflow_err
);

  localparam int SLOT_W    = DRAM_BLOCK_RDWR_ADDR_WIDTH;
  localparam int PTR_SHIFT = $clog2(DRAM_BLOCK_SIZE);
  // A block occupies DRAM_BLOCK_SIZE/2 FIFO entries, so a fetch may start only
  // while at least that many entries are free.
  localparam logic [FIFO_CNT_WIDTH-1:0] SPACE_THRESH =
    FIFO_CNT_WIDTH'(FIFO_DEPTH - DRAM_BLOCK_SIZE / 2);

  typedef enum logic [2:0] {
    ST_WAIT_FOR_BLOCK = 3'b001,
    ST_REQ            = 3'b010,
    ST_READ           = 3'b100
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SLOT_W-1:0]  r_oq_rd_addr;
  logic [SLOT_W-1:0]  r_blk_hi;
  logic [SLOT_W-1:0]  r_blk_lo;
  logic               r_overflow_err;
  logic [SLOT_W-1:0]  w_next_slot;
  logic               w_blk_avail;
  logic               w_fifo_space;
  logic               w_init;
  logic               w_abort;
  logic               w_advance;
  logic               w_set_ovf;
  logic               w_rd_req;
  logic               w_wr_en;
  logic               w_words;
  logic               w_blocks;

  assign w_init       = i_ctrl[OQ_CONTROL_INITIALIZE_OQ_POS];
  // Reset and initialise both cancel whatever the current cycle would do.
  assign w_abort      = i_reset | w_init;
  assign w_blk_avail  = (r_oq_rd_addr != i_oq_wr_addr);
  assign w_fifo_space = (i_fifo_wr_data_count <= SPACE_THRESH);
  assign w_next_slot  = (r_oq_rd_addr >= r_blk_hi) ? r_blk_lo
                                                   : r_oq_rd_addr + SLOT_W'(1);

  // The read pointer is derived from the slot index, which only moves on done
  // or initialise, so it stays stable for the whole transfer.
  assign o_dram_rd_ptr    = DRAM_ADDR_WIDTH'(r_oq_rd_addr) << PTR_SHIFT;
  assign o_oq_rd_addr     = r_oq_rd_addr;
  assign o_fifo_din       = i_dram_rd_data;
  assign o_fifo_wr_en     = w_wr_en;
  assign o_dram_rd_req    = w_rd_req;
  assign o_dram_rd_words  = w_words;
  assign o_blocks_fetched = w_blocks;
  assign o_overflow_err   = r_overflow_err;

  // Ring bounds are sampled every cycle; they are configuration, not state.
  always_ff @(posedge i_clk) begin
    r_blk_hi <= i_block_addr_hi;
    r_blk_lo <= i_block_addr_lo;
  end

  // State, reader slot and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_WAIT_FOR_BLOCK;
      r_oq_rd_addr   <= SLOT_W'(DEFAULT_ADDR);
      r_overflow_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_init) begin
        r_oq_rd_addr <= r_blk_lo;
      end else if (w_advance) begin
        r_oq_rd_addr <= w_next_slot;
      end
      if (w_set_ovf) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Next-state and per-cycle outputs. Words arriving while the FIFO is full
  // are dropped; vld/done outside ST_READ are ignored.
  always_comb begin
    w_state_next = r_state;
    w_rd_req     = 1'b0;
    w_wr_en      = 1'b0;
    w_words      = 1'b0;
    w_blocks     = 1'b0;
    w_advance    = 1'b0;
    w_set_ovf    = 1'b0;
    if (w_abort) begin
      w_state_next = ST_WAIT_FOR_BLOCK;
    end else begin
      case (r_state)
        ST_WAIT_FOR_BLOCK: begin
          if (w_blk_avail && w_fifo_space) begin
            w_state_next = ST_REQ;
          end
        end
        ST_REQ: begin
          w_rd_req = 1'b1;
          if (i_dram_rd_ack) begin
            w_state_next = ST_READ;
          end
        end
        ST_READ: begin
          if (i_dram_rd_data_vld) begin
            if (i_fifo_full) begin
              w_set_ovf = 1'b1;
            end else begin
              w_wr_en = 1'b1;
              w_words = 1'b1;
            end
          end
          if (i_dram_rd_done) begin
            w_advance    = 1'b1;
            w_blocks     = 1'b1;
            w_state_next = ST_WAIT_FOR_BLOCK;
          end
        end
        default: begin
          w_state_next = ST_WAIT_FOR_BLOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pkt_dram.sv
// ---------------------------------------------------------------------------
// tb_fetch_pkt_dram
// Scoreboard bench for fetch_pkt_dram. Stimulus pushes each word it expects to
// see at the FIFO write port into a queue; a monitor on the falling edge pops
// and compares whenever the DUT strobes fifo_wr_en.
// ---------------------------------------------------------------------------
module tb_fetch_pkt_dram;

  logic          clk;
  logic          reset;
  logic [2:0]    oqWrAddr;
  logic [2:0]    oqRdAddr;
  logic          dramRdReq;
  logic [21:0]   dramRdPtr;
  logic          dramRdAck;
  logic [143:0]  dramRdData;
  logic          dramRdVld;
  logic          dramRdDone;
  logic [143:0]  fifoDin;
  logic          fifoWrEn;
  logic [8:0]    fifoCount;
  logic          fifoFull;
  logic [2:0]    blkHi;
  logic [2:0]    blkLo;
  logic [1:0]    ctrl;
  logic          rdWords;
  logic          blocksFetched;
  logic          overflowErr;

  int            checksPassed = 0;
  int            checksTotal  = 0;
  int            writesSeen   = 0;
  int            wordsSeen    = 0;
  int            blocksSeen   = 0;
  logic [143:0]  expQ[$];

  fetch_pkt_dram dut (
    .i_clk                (clk),
    .i_reset              (reset),
    .i_oq_wr_addr         (oqWrAddr),
    .o_oq_rd_addr         (oqRdAddr),
    .o_dram_rd_req        (dramRdReq),
    .o_dram_rd_ptr        (dramRdPtr),
    .i_dram_rd_ack        (dramRdAck),
    .i_dram_rd_data       (dramRdData),
    .i_dram_rd_data_vld   (dramRdVld),
    .i_dram_rd_done       (dramRdDone),
    .o_fifo_din           (fifoDin),
    .o_fifo_wr_en         (fifoWrEn),
    .i_fifo_wr_data_count (fifoCount),
    .i_fifo_full          (fifoFull),
    .i_block_addr_hi      (blkHi),
    .i_block_addr_lo      (blkLo),
    .i_ctrl               (ctrl),
    .o_dram_rd_words      (rdWords),
    .o_blocks_fetched     (blocksFetched),
    .o_overflow_err       (overflowErr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got hang, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Scoreboard monitor: compare every FIFO write against the expected queue.
  always @(negedge clk) begin
    if (fifoWrEn) begin
      writesSeen++;
      checksTotal++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL fifo_write: got unexpected write %h, expected no write", fifoDin);
      end else begin
        logic [143:0] exp;
        exp = expQ.pop_front();
        if (fifoDin === exp) checksPassed++;
        else $display("[TB] FAIL fifo_din: got %h, expected %h", fifoDin, exp);
      end
    end
    if (rdWords) wordsSeen++;
    if (blocksFetched) blocksSeen++;
  end

  function automatic logic [143:0] mkWord(input logic [7:0] tag, input logic [7:0] idx);
    return {tag, idx, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210 ^ {8{idx}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Waits up to maxCyc falling edges for a request; returns at that edge.
  task automatic waitReq(input int maxCyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (dramRdReq) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Streams nWords returned words; the word at fullIdx arrives while the FIFO
  // reports full and must be dropped. done accompanies the last word if set.
  task automatic applyStimulus(input logic [7:0] tag, input int nWords,
                               input int fullIdx, input bit withDone);
    for (int i = 0; i < nWords; i++) begin
      dramRdVld  = 1'b1;
      dramRdData = mkWord(tag, 8'(i));
      dramRdDone = withDone && (i == nWords - 1);
      fifoFull   = (i == fullIdx);
      if (i != fullIdx) expQ.push_back(mkWord(tag, 8'(i)));
      tick();
    end
    dramRdVld  = 1'b0;
    dramRdDone = 1'b0;
    fifoFull   = 1'b0;
  endtask

  // Accept a pending request: ack for one cycle.
  task automatic ackReq();
    tick();
    dramRdAck = 1'b1;
    tick();
    dramRdAck = 1'b0;
  endtask

  initial begin
    bit found;
    int reqSeen;

    reset      = 1'b1;
    oqWrAddr   = 3'd0;
    dramRdAck  = 1'b0;
    dramRdData = '0;
    dramRdVld  = 1'b0;
    dramRdDone = 1'b0;
    fifoCount  = 9'd0;
    fifoFull   = 1'b0;
    blkHi      = 3'd7;
    blkLo      = 3'd0;
    ctrl       = 2'b00;
    repeat (3) tick();
    reset = 1'b0;

    @(negedge clk);
    checkOutput("reset_rd_addr", 32'(oqRdAddr), 32'd0);
    checkOutput("reset_req", 32'(dramRdReq), 32'd0);
    checkOutput("reset_overflow", 32'(overflowErr), 32'd0);
    checkOutput("reset_wr_en", 32'(fifoWrEn), 32'd0);

    // Empty ring: no request for 100 cycles.
    $display("[TB] empty ring");
    reqSeen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      @(negedge clk);
      if (dramRdReq) reqSeen++;
    end
    checkOutput("empty_no_req", 32'(reqSeen), 32'd0);

    // One full 64-word block from slot 0; request held until ack.
    $display("[TB] full block from slot 0");
    tick();
    oqWrAddr = 3'd1;
    waitReq(4, found);
    checkOutput("blk0_req", 32'(found), 32'd1);
    checkOutput("blk0_ptr", 32'(dramRdPtr), 32'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("blk0_req_hold", 32'(dramRdReq), 32'd1);
    ackReq();
    writesSeen = 0; wordsSeen = 0; blocksSeen = 0;
    applyStimulus(8'h02, 64, -1, 1'b1);
    @(negedge clk);
    checkOutput("blk0_rd_addr", 32'(oqRdAddr), 32'd1);
    checkOutput("blk0_writes", 32'(writesSeen), 32'd64);
    checkOutput("blk0_words", 32'(wordsSeen), 32'd64);
    checkOutput("blk0_blocks", 32'(blocksSeen), 32'd1);
    checkOutput("blk0_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("blk0_no_rereq", 32'(dramRdReq), 32'd0);

    // Slot 7 at the top of the ring: ptr 896, wraps to lo afterwards.
    $display("[TB] wrap from slot 7");
    tick();
    fifoCount = 9'd500;
    oqWrAddr  = 3'd0;
    blkLo     = 3'd7;
    tick();
    ctrl = 2'b01;
    tick();
    ctrl  = 2'b00;
    blkLo = 3'd0;
    tick();
    @(negedge clk);
    checkOutput("init7_rd_addr", 32'(oqRdAddr), 32'd7);
    checkOutput("init7_no_req_full", 32'(dramRdReq), 32'd0);
    tick();
    fifoCount = 9'd0;
    waitReq(4, found);
    checkOutput("blk7_req", 32'(found), 32'd1);
    checkOutput("blk7_ptr", 32'(dramRdPtr), 32'd896);
    ackReq();
    applyStimulus(8'h07, 8, -1, 1'b1);
    @(negedge clk);
    checkOutput("blk7_wrap_rd_addr", 32'(oqRdAddr), 32'd0);

    // FIFO space threshold: 449 blocks, 448 allows.
    $display("[TB] fifo space threshold");
    tick();
    oqWrAddr  = 3'd3;
    fifoCount = 9'd449;
    reqSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (dramRdReq) reqSeen++;
    end
    checkOutput("space449_no_req", 32'(reqSeen), 32'd0);
    tick();
    fifoCount = 9'd448;
    waitReq(2, found);
    checkOutput("space448_req", 32'(found), 32'd1);
    checkOutput("space448_ptr", 32'(dramRdPtr), 32'd0);
    ackReq();
    blocksSeen = 0;
    applyStimulus(8'h04, 4, -1, 1'b1);
    @(negedge clk);
    checkOutput("space448_rd_addr", 32'(oqRdAddr), 32'd1);
    checkOutput("space448_blocks", 32'(blocksSeen), 32'd1);

    // Word arriving while fifo_full is dropped and overflow latches.
    $display("[TB] overflow");
    checkOutput("ovf_before", 32'(overflowErr), 32'd0);
    waitReq(4, found);
    checkOutput("ovf_req", 32'(found), 32'd1);
    checkOutput("ovf_ptr", 32'(dramRdPtr), 32'd128);
    ackReq();
    writesSeen = 0;
    applyStimulus(8'h05, 4, 1, 1'b1);
    @(negedge clk);
    checkOutput("ovf_writes", 32'(writesSeen), 32'd3);
    checkOutput("ovf_set", 32'(overflowErr), 32'd1);
    checkOutput("ovf_rd_addr", 32'(oqRdAddr), 32'd2);

    // Initialise mid-transfer: trailing vld/done are ignored.
    $display("[TB] initialise mid-transfer");
    tick();
    oqWrAddr = 3'd5;
    waitReq(4, found);
    checkOutput("blk2_ptr", 32'(dramRdPtr), 32'd256);
    ackReq();
    applyStimulus(8'h06, 4, -1, 1'b1);
    waitReq(4, found);
    checkOutput("blk3_req", 32'(found), 32'd1);
    checkOutput("blk3_ptr", 32'(dramRdPtr), 32'd384);
    ackReq();
    applyStimulus(8'h08, 2, -1, 1'b0);
    blkLo    = 3'd2;
    oqWrAddr = 3'd2;
    tick();
    ctrl = 2'b01;
    tick();
    ctrl = 2'b00;
    @(negedge clk);
    checkOutput("init_rd_addr", 32'(oqRdAddr), 32'd2);
    tick();
    writesSeen = 0; blocksSeen = 0;
    dramRdVld  = 1'b1;
    dramRdData = mkWord(8'hEE, 8'h00);
    @(negedge clk);
    checkOutput("trail_wr_en", 32'(fifoWrEn), 32'd0);
    tick();
    dramRdDone = 1'b1;
    tick();
    dramRdVld  = 1'b0;
    dramRdDone = 1'b0;
    @(negedge clk);
    checkOutput("trail_writes", 32'(writesSeen), 32'd0);
    checkOutput("trail_blocks", 32'(blocksSeen), 32'd0);
    checkOutput("trail_rd_addr", 32'(oqRdAddr), 32'd2);
    checkOutput("trail_no_req", 32'(dramRdReq), 32'd0);
    checkOutput("ovf_sticky", 32'(overflowErr), 32'd1);

    // Reset clears the sticky flag and returns to the default slot.
    $display("[TB] final reset");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst2_overflow", 32'(overflowErr), 32'd0);
    checkOutput("rst2_rd_addr", 32'(oqRdAddr), 32'd0);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    tick();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
